// File: rtl/csm_pkg.sv
// csm_pkg: status codes, command record and sequencer states shared by the csm port logic
package csm_pkg;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BUSY    = 2'd1;
  localparam logic [1:0] ERR_ADDR    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       lock;
    logic       unlock;
  } csm_cmd_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_REL} csm_state_t;
endpackage

// File: rtl/csm_cmd_fifo.sv
// csm_cmd_fifo: synchronous command FIFO with full/empty flags
module csm_cmd_fifo
  import csm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  csm_cmd_t din,
  output csm_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  csm_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/csm_port_master.sv
// csm_port_master: turns buffered client commands into csm address/data port transfers
module csm_port_master
  import csm_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_lock,
  input  logic       cmd_unlock,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic [7:0] csm_AD,
  output logic       csm_rw,
  output logic       csm_enable,
  output logic       csm_hold,
  output logic       csm_release,
  input  logic       csm_ack,
  input  logic [7:0] csm_out_data,
  input  logic [1:0] csm_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  csm_state_t state;
  csm_cmd_t cmd_in, head;
  logic full, empty, pop, fin, got_lock, lock_active;
  logic w_rw, w_lock, w_unlock;
  logic [7:0] w_wdata;
  logic [CW-1:0] tmo_cnt;
  logic [1:0] fin_err;
  assign cmd_in = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata, lock: cmd_lock, unlock: cmd_unlock};
  assign cmd_ready = !full;
  assign pop = state == S_IDLE && !empty;
  assign busy = state != S_IDLE || !empty;
  // an ack arriving on the last allowed cycle takes priority over the timeout
  assign fin = csm_ack || tmo_cnt == CW'(TIMEOUT - 1);
  assign fin_err = csm_ack ? csm_err : ERR_TIMEOUT;
  assign got_lock = lock_active || (w_lock && fin_err == ERR_NONE);
  csm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(cmd_valid), .pop(pop),
    .din(cmd_in), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    rsp_valid <= 1'b0;
    csm_release <= 1'b0;
    if (reset) begin
      state <= S_IDLE;
      {w_rw, w_wdata, w_lock, w_unlock} <= '0;
      lock_active <= 1'b0;
      tmo_cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= '0;
      csm_AD <= '0;
      csm_rw <= 1'b0;
      csm_enable <= 1'b0;
      csm_hold <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          state <= S_ADDR;
          {w_rw, w_wdata, w_lock, w_unlock} <= {head.rw, head.wdata, head.lock, head.unlock};
          csm_enable <= 1'b1;
          csm_AD <= head.addr;
          csm_rw <= head.rw;
          csm_hold <= lock_active || head.lock;
        end
        S_ADDR: begin
          state <= S_DATA;
          csm_AD <= w_rw ? 8'h00 : w_wdata;
          tmo_cnt <= '0;
        end
        S_DATA, S_WAIT: if (fin) begin
          state <= w_unlock ? S_REL : S_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= csm_ack && w_rw ? csm_out_data : 8'h00;
          rsp_err <= fin_err;
          csm_enable <= 1'b0;
          csm_AD <= '0;
          csm_rw <= 1'b0;
          csm_release <= w_unlock;
          lock_active <= !w_unlock && got_lock;
          csm_hold <= !w_unlock && got_lock;
        end else begin
          state <= S_WAIT;
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csm_port_master.sv
// tb_csm_port_master: directed and randomized transfers checked against a transaction-level model
module tb_csm_port_master;
  import csm_pkg::*;
  localparam int TMO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_lock = 1'b0, cmd_unlock = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0, csm_out_data = '0;
  logic csm_ack = 1'b0;
  logic [1:0] csm_err = '0;
  logic cmd_ready, rsp_valid, busy, csm_rw, csm_enable, csm_hold, csm_release;
  logic [7:0] rsp_rdata, csm_AD;
  logic [1:0] rsp_err;
  int vectors = 0, miscompares = 0;
  logic locked = 1'b0;

  csm_port_master #(.DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_lock(cmd_lock), .cmd_unlock(cmd_unlock), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .csm_AD(csm_AD),
    .csm_rw(csm_rw), .csm_enable(csm_enable), .csm_hold(csm_hold),
    .csm_release(csm_release), .csm_ack(csm_ack), .csm_out_data(csm_out_data),
    .csm_err(csm_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [7:0] addr, wdata, input logic lk, ul);
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_addr = addr;
    cmd_wdata = wdata;
    cmd_lock = lk;
    cmd_unlock = ul;
  endtask

  // one command from push to idle; dly = DATA/WAIT cycle index of the ack, >= TMO means no ack
  task automatic run_cmd(input logic rw, input logic [7:0] addr, wdata, input logic lk, ul,
                         input int dly, input logic [7:0] od, input logic [1:0] ce, input logic ack_addr);
    logic [1:0] e_err;
    logic [7:0] e_rd, e_ad;
    logic hx, done;
    e_err = dly < TMO ? ce : ERR_TIMEOUT;
    e_rd = (dly < TMO && rw) ? od : 8'h00;
    e_ad = rw ? 8'h00 : wdata;
    hx = locked | lk;
    push(rw, addr, wdata, lk, ul);
    tick;
    cmd_valid = 1'b0;
    chk("idle_enable", csm_enable, 0);
    chk("idle_busy", busy, 1);
    chk("idle_hold", csm_hold, locked);
    tick;
    chk("addr_enable", csm_enable, 1);
    chk("addr_ad", csm_AD, addr);
    chk("addr_rw", csm_rw, rw);
    chk("addr_hold", csm_hold, hx);
    csm_ack = ack_addr;
    csm_err = ERR_ADDR;
    csm_out_data = ~od;
    tick;
    csm_ack = 1'b0;
    chk("data_enable", csm_enable, 1);
    chk("data_ad", csm_AD, e_ad);
    chk("data_rsp", rsp_valid, 0);
    done = 1'b0;
    for (int n = 0; n < TMO + 2 && !done; n++) begin
      csm_ack = (n == dly);
      csm_out_data = od;
      csm_err = ce;
      tick;
      csm_ack = 1'b0;
      done = (n == dly) || (n == TMO - 1);
      chk("rsp_valid", rsp_valid, done);
      if (!done) begin
        chk("wait_enable", csm_enable, 1);
        chk("wait_ad", csm_AD, e_ad);
        chk("wait_hold", csm_hold, hx);
      end
    end
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("rsp_err", rsp_err, e_err);
    chk("done_enable", csm_enable, 0);
    if (ul) begin
      locked = 1'b0;
      chk("rel_pulse", csm_release, 1);
      chk("rel_hold", csm_hold, 0);
      tick;
      chk("rel_end", csm_release, 0);
    end else begin
      locked = locked | (lk && e_err == ERR_NONE);
      chk("no_release", csm_release, 0);
      chk("done_hold", csm_hold, locked);
      tick;
    end
    chk("rsp_once", rsp_valid, 0);
    chk("post_hold", csm_hold, locked);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic pe;
    int got;
    tick;
    tick;
    chk("rst_enable", csm_enable, 0);
    chk("rst_hold", csm_hold, 0);
    chk("rst_release", csm_release, 0);
    chk("rst_ad", csm_AD, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    tick;
    run_cmd(1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0, 0, 8'h77, ERR_NONE, 1'b0);
    run_cmd(1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 3, 8'hA5, ERR_NONE, 1'b0);
    run_cmd(1'b0, 8'h40, 8'h12, 1'b1, 1'b0, 1, 8'h00, ERR_NONE, 1'b0);
    chk("lock_kept", csm_hold, 1);
    run_cmd(1'b1, 8'h41, 8'h00, 1'b0, 1'b1, 2, 8'h9C, ERR_NONE, 1'b0);
    run_cmd(1'b0, 8'h42, 8'h34, 1'b1, 1'b0, 0, 8'h00, ERR_BUSY, 1'b0);
    chk("lock_failed", csm_hold, 0);
    run_cmd(1'b1, 8'h55, 8'h00, 1'b0, 1'b0, TMO + 5, 8'hEE, ERR_NONE, 1'b1);
    // stalled controller: five pushes fit (one in flight, four queued), the sixth is refused
    for (int i = 0; i < 6; i++) begin
      chk("fill_ready", cmd_ready, i < 5);
      push(1'b1, 8'(i), 8'h00, 1'b0, 1'b0);
      if (i < 5) exp_q.push_back(8'(i) ^ 8'h5A);
      tick;
    end
    cmd_valid = 1'b0;
    chk("full_ready", cmd_ready, 0);
    pe = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      csm_ack = csm_enable && pe;
      csm_out_data = exp_q.size() != 0 ? exp_q[0] : 8'h00;
      csm_err = ERR_NONE;
      pe = csm_enable;
      tick;
      csm_ack = 1'b0;
      if (rsp_valid) begin
        chk("fifo_rdata", rsp_rdata, exp_q.size() != 0 ? exp_q.pop_front() : 8'hXX);
        got++;
        chk("fifo_busy", busy, exp_q.size() != 0);
      end
    end
    chk("fifo_count", got, 5);
    tick;
    chk("fifo_idle", busy, 0);
    for (int k = 0; k < 40; k++) begin
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 18)), 8'($urandom), 2'($urandom_range(0, 2)), 1'($urandom));
    end
    run_cmd(1'b0, 8'h10, 8'h11, 1'b1, 1'b0, 0, 8'h00, ERR_NONE, 1'b0);
    push(1'b0, 8'h20, 8'h21, 1'b0, 1'b0);
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    push(1'b1, 8'h30, 8'h00, 1'b0, 1'b0);
    tick;
    cmd_valid = 1'b0;
    chk("pre_rst_hold", csm_hold, 1);
    chk("pre_rst_enable", csm_enable, 1);
    reset = 1'b1;
    tick;
    chk("mid_rst_enable", csm_enable, 0);
    chk("mid_rst_hold", csm_hold, 0);
    chk("mid_rst_release", csm_release, 0);
    chk("mid_rst_ad", csm_AD, 0);
    chk("mid_rst_rw", csm_rw, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    reset = 1'b0;
    locked = 1'b0;
    tick;
    chk("after_rst_rsp", rsp_valid, 0);
    chk("after_rst_release", csm_release, 0);
    chk("after_rst_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
